// File: rtl/tx_interface_if.sv
// Bundle between the ALU result side and the UART tx core.
// The return-path block uses the slave view. The driver of results and tx_done uses the master view.
interface tx_interface_if #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned RESULT_BYTES = 1
);
    logic [RESULT_BYTES*DATA_BITS-1:0] i_result;
    logic                              i_result_valid;
    logic                              i_tx_done;
    logic [DATA_BITS-1:0]              o_tx_data;
    logic                              o_tx_start;
    logic                              o_busy;
    logic                              o_frame_done;
    logic                              o_drop;
    logic                              o_error;

    modport slave (
        input  i_result, i_result_valid, i_tx_done,
        output o_tx_data, o_tx_start, o_busy, o_frame_done, o_drop, o_error
    );

    modport master (
        output i_result, i_result_valid, i_tx_done,
        input  o_tx_data, o_tx_start, o_busy, o_frame_done, o_drop, o_error
    );
endinterface

// File: rtl/tx_interface.sv
// Captures an ALU result on a valid rising edge and sends it MSB byte first to the UART tx.
// Each byte waits for a tx_done rising edge before the next byte starts. A header byte and a per-byte timeout are optional.
module tx_interface #(
    parameter int unsigned          DATA_BITS      = 8,
    parameter int unsigned          RESULT_BYTES   = 1,
    parameter int unsigned          SEND_HEADER    = 0,
    parameter logic [DATA_BITS-1:0] HEADER_BYTE    = 8'hA5,
    parameter int unsigned          TIMEOUT_CYCLES = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    tx_interface_if.slave bus
);
    localparam int unsigned RES_W    = RESULT_BYTES * DATA_BITS;
    localparam int unsigned HDR      = (SEND_HEADER != 0) ? 1 : 0;
    localparam int unsigned REM_INIT = RESULT_BYTES + HDR - 1;
    localparam int unsigned REM_W    = (REM_INIT > 0) ? $clog2(REM_INIT + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam int unsigned TMO_W    = (TMO_LAST > 0) ? $clog2(TMO_LAST + 1) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state_q, state_n;
    logic [RES_W-1:0]     sh_q, sh_n;
    logic [REM_W-1:0]     rem_q, rem_n;
    logic [TMO_W-1:0]     cnt_q, cnt_n;
    logic [DATA_BITS-1:0] data_q, data_n;
    logic                 start_q, start_n;
    logic                 busy_q, busy_n;
    logic                 fdone_q, fdone_n;
    logic                 drop_q, drop_n;
    logic                 err_q, err_n;
    logic                 valid_hist_q, done_hist_q;
    logic                 valid_rise, done_rise;

    // History resets high so that an input already asserted at reset release is not seen as an edge.
    assign valid_rise = bus.i_result_valid & ~valid_hist_q;
    assign done_rise  = bus.i_tx_done & ~done_hist_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            data_q       <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            fdone_q      <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            valid_hist_q <= 1'b1;
            done_hist_q  <= 1'b1;
        end else begin
            state_q      <= state_n;
            sh_q         <= sh_n;
            rem_q        <= rem_n;
            cnt_q        <= cnt_n;
            data_q       <= data_n;
            start_q      <= start_n;
            busy_q       <= busy_n;
            fdone_q      <= fdone_n;
            drop_q       <= drop_n;
            err_q        <= err_n;
            valid_hist_q <= bus.i_result_valid;
            done_hist_q  <= bus.i_tx_done;
        end
    end

    always_comb begin
        state_n = state_q;
        sh_n    = sh_q;
        rem_n   = rem_q;
        cnt_n   = cnt_q;
        data_n  = data_q;
        start_n = 1'b0;
        busy_n  = busy_q;
        fdone_n = 1'b0;
        drop_n  = 1'b0;
        err_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_rise) begin
                    if (HDR != 0) begin
                        data_n = HEADER_BYTE;
                        sh_n   = bus.i_result;
                    end else begin
                        data_n = bus.i_result[RES_W-1 -: DATA_BITS];
                        sh_n   = bus.i_result << DATA_BITS;
                    end
                    rem_n   = REM_W'(REM_INIT);
                    cnt_n   = '0;
                    start_n = 1'b1;
                    busy_n  = 1'b1;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                drop_n = valid_rise;
                // A done edge takes priority over a timeout in the same cycle.
                if (done_rise) begin
                    if (rem_q != '0) begin
                        data_n  = sh_q[RES_W-1 -: DATA_BITS];
                        sh_n    = sh_q << DATA_BITS;
                        rem_n   = rem_q - REM_W'(1);
                        cnt_n   = '0;
                        start_n = 1'b1;
                    end else begin
                        busy_n  = 1'b0;
                        fdone_n = 1'b1;
                        state_n = IDLE;
                    end
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (cnt_q == TMO_W'(TMO_LAST)) begin
                        busy_n  = 1'b0;
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt_q + TMO_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.o_tx_data    = data_q;
    assign bus.o_tx_start   = start_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_frame_done = fdone_q;
    assign bus.o_drop       = drop_q;
    assign bus.o_error      = err_q;
endmodule

// File: tb/tb_tx_interface.sv
// Directed bench for tx_interface, with two instances.
// Instance a is a single byte with a 16-cycle timeout. Instance b has two result bytes plus a header and no timeout.
module tb_tx_interface;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tx_interface_if #(.DATA_BITS(8), .RESULT_BYTES(1)) if_a ();
    tx_interface_if #(.DATA_BITS(8), .RESULT_BYTES(2)) if_b ();

    tx_interface #(
        .DATA_BITS(8), .RESULT_BYTES(1), .SEND_HEADER(0),
        .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(16)
    ) u_a (
        .i_clk(clk), .i_rst(rst_n), .bus(if_a)
    );

    tx_interface #(
        .DATA_BITS(8), .RESULT_BYTES(2), .SEND_HEADER(1),
        .HEADER_BYTE(8'hA5), .TIMEOUT_CYCLES(0)
    ) u_b (
        .i_clk(clk), .i_rst(rst_n), .bus(if_b)
    );

    typedef struct {
        logic       v;
        logic       d;
        logic [7:0] r;
        logic       es;
        logic [7:0] ed;
        logic       eb;
        logic       efd;
        logic       edr;
        logic       eer;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic v, input logic d, input logic [7:0] r,
                                input logic es, input logic [7:0] ed, input logic eb,
                                input logic efd, input logic edr, input logic eer);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.es = es; t.ed = ed;
        t.eb = eb; t.efd = efd; t.edr = edr; t.eer = eer;
        vq.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step_a(input logic v, input logic d, input logic [7:0] r);
        @(negedge clk);
        if_a.i_result_valid = v;
        if_a.i_tx_done      = d;
        if_a.i_result       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic v, input logic d, input logic [15:0] r);
        @(negedge clk);
        if_b.i_result_valid = v;
        if_b.i_tx_done      = d;
        if_b.i_result       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_b(input string name, input logic es, input logic [7:0] ed,
                         input logic eb, input logic efd);
        chk({name, " b.start"}, 32'(if_b.o_tx_start), 32'(es));
        chk({name, " b.data"}, 32'(if_b.o_tx_data), 32'(ed));
        chk({name, " b.busy"}, 32'(if_b.o_busy), 32'(eb));
        chk({name, " b.frame_done"}, 32'(if_b.o_frame_done), 32'(efd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        if_a.i_result = '0; if_a.i_result_valid = 1'b0; if_a.i_tx_done = 1'b0;
        if_b.i_result = '0; if_b.i_result_valid = 1'b0; if_b.i_tx_done = 1'b0;

        // Single byte: 3C, with done 10 cycles after the start
        add(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 8'h3C, 1, 8'h3C, 1, 0, 0, 0);
        add(1, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h3C, 0, 1, 0, 0);
        add(0, 1, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 0);
        // A second valid edge during the 22 frame is dropped
        add(1, 0, 8'h22, 1, 8'h22, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0);
        add(1, 0, 8'h11, 0, 8'h22, 1, 0, 1, 0);
        add(0, 0, 8'h00, 0, 8'h22, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h22, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 8'h22, 0, 0, 0, 0);
        // A valid edge in the same cycle as the final done is dropped
        add(1, 0, 8'h44, 1, 8'h44, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h44, 1, 0, 0, 0);
        add(1, 1, 8'h55, 0, 8'h44, 0, 1, 1, 0);
        add(0, 0, 8'h00, 0, 8'h44, 0, 0, 0, 0);
        add(1, 0, 8'h55, 1, 8'h55, 1, 0, 0, 0);
        add(0, 0, 8'h00, 0, 8'h55, 1, 0, 0, 0);
        add(0, 1, 8'h00, 0, 8'h55, 0, 1, 0, 0);
        add(0, 0, 8'h00, 0, 8'h55, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset a.busy", 32'(if_a.o_busy), 32'd0);
        chk("reset a.data", 32'(if_a.o_tx_data), 32'd0);
        chk("reset a.start", 32'(if_a.o_tx_start), 32'd0);
        chk("reset b.busy", 32'(if_b.o_busy), 32'd0);
        chk("reset b.data", 32'(if_b.o_tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Header frame, BEEF -> A5 BE EF
        step_b(0, 0, 16'h0000); exp_b("hdr idle", 0, 8'h00, 0, 0);
        step_b(1, 0, 16'hBEEF); exp_b("hdr A5", 1, 8'hA5, 1, 0);
        step_b(0, 0, 16'h0000); exp_b("hdr wait1", 0, 8'hA5, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hdr BE", 1, 8'hBE, 1, 0);
        step_b(0, 0, 16'h0000); exp_b("hdr wait2", 0, 8'hBE, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hdr EF", 1, 8'hEF, 1, 0);
        step_b(0, 0, 16'h0000); exp_b("hdr wait3", 0, 8'hEF, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hdr end", 0, 8'hEF, 0, 1);
        step_b(0, 0, 16'h0000); exp_b("hdr idle2", 0, 8'hEF, 0, 0);

        // A done held high counts once
        step_b(1, 0, 16'h1234); exp_b("hold A5", 1, 8'hA5, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hold 12", 1, 8'h12, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step_b(0, 1, 16'h0000); exp_b("hold high", 0, 8'h12, 1, 0);
        end
        step_b(0, 0, 16'h0000); exp_b("hold low", 0, 8'h12, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hold 34", 1, 8'h34, 1, 0);
        step_b(0, 0, 16'h0000); exp_b("hold wait", 0, 8'h34, 1, 0);
        step_b(0, 1, 16'h0000); exp_b("hold end", 0, 8'h34, 0, 1);

        for (int i = 0; i < vq.size(); i++) begin
            step_a(vq[i].v, vq[i].d, vq[i].r);
            chk($sformatf("vec%0d start", i), 32'(if_a.o_tx_start), 32'(vq[i].es));
            chk($sformatf("vec%0d data", i), 32'(if_a.o_tx_data), 32'(vq[i].ed));
            chk($sformatf("vec%0d busy", i), 32'(if_a.o_busy), 32'(vq[i].eb));
            chk($sformatf("vec%0d frame_done", i), 32'(if_a.o_frame_done), 32'(vq[i].efd));
            chk($sformatf("vec%0d drop", i), 32'(if_a.o_drop), 32'(vq[i].edr));
            chk($sformatf("vec%0d error", i), 32'(if_a.o_error), 32'(vq[i].eer));
        end

        // Timeout: error 16 cycles after the start, then a fresh frame
        step_a(1, 0, 8'h77);
        chk("tmo start", 32'(if_a.o_tx_start), 32'd1);
        for (int i = 1; i < 16; i++) begin
            step_a(0, 0, 8'h00);
            chk($sformatf("tmo busy c%0d", i), 32'(if_a.o_busy), 32'd1);
            chk($sformatf("tmo error c%0d", i), 32'(if_a.o_error), 32'd0);
        end
        step_a(0, 0, 8'h00);
        chk("tmo error", 32'(if_a.o_error), 32'd1);
        chk("tmo busy", 32'(if_a.o_busy), 32'd0);
        chk("tmo frame_done", 32'(if_a.o_frame_done), 32'd0);
        step_a(0, 0, 8'h00);
        chk("tmo error pulse", 32'(if_a.o_error), 32'd0);
        step_a(1, 0, 8'h99);
        chk("tmo next start", 32'(if_a.o_tx_start), 32'd1);
        chk("tmo next data", 32'(if_a.o_tx_data), 32'h99);
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h00);
        chk("tmo next frame_done", 32'(if_a.o_frame_done), 32'd1);

        // Async reset mid-frame, with valid held through release
        step_a(1, 0, 8'h5A);
        chk("rst start", 32'(if_a.o_tx_start), 32'd1);
        step_a(1, 0, 8'h5A);
        chk("rst pre busy", 32'(if_a.o_busy), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async busy", 32'(if_a.o_busy), 32'd0);
        chk("rst async data", 32'(if_a.o_tx_data), 32'd0);
        chk("rst async b.data", 32'(if_b.o_tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step_a(1, 0, 8'h00);
            chk($sformatf("rst held start c%0d", i), 32'(if_a.o_tx_start), 32'd0);
            chk($sformatf("rst held busy c%0d", i), 32'(if_a.o_busy), 32'd0);
        end
        step_a(0, 0, 8'h00);
        step_a(1, 0, 8'hC3);
        chk("rst restart start", 32'(if_a.o_tx_start), 32'd1);
        chk("rst restart data", 32'(if_a.o_tx_data), 32'hC3);
        step_a(0, 0, 8'h00);
        step_a(0, 1, 8'h00);
        chk("rst restart frame_done", 32'(if_a.o_frame_done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
